// File: rtl/udp_packet_builder_if.sv
// Frame-builder handshake bundle: request/config, payload input stream,
// frame output stream and status pulses.
interface udp_packet_builder_if;
    logic        tx_start;
    logic [10:0] tx_payload_len;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_error;

    modport master (
        output tx_start, tx_payload_len, dst_mac, src_mac, src_ip, dst_ip,
               src_port, dst_port, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_start, tx_payload_len, dst_mac, src_mac, src_ip, dst_ip,
               src_port, dst_port, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/udp_packet_builder.sv
// Builds Ethernet/IPv4/UDP frames: 42 header bytes with a precomputed IPv4
// checksum, followed by a pass-through payload stream.
module udp_packet_builder #(
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter int unsigned IP_TTL      = 64,
    parameter int unsigned MIN_GAP     = 1
) (
    input logic clk,
    input logic reset,
    udp_packet_builder_if.slave bus
);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [7:0]  TTL      = 8'(IP_TTL);
    localparam logic [15:0] GAP_LAST = 16'(MIN_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECKSUM, S_HEADER, S_PAYLOAD, S_GAP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [16:0] acc_q;
    logic [15:0] checksum_q;
    logic [15:0] id_q;
    logic [15:0] len_q;
    logic [15:0] rem_q;
    logic [15:0] gap_q;
    logic [5:0]  idx_q;
    logic [47:0] dst_mac_q;
    logic [47:0] src_mac_q;
    logic [31:0] src_ip_q;
    logic [31:0] dst_ip_q;
    logic [15:0] src_port_q;
    logic [15:0] dst_port_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic [15:0]  total_len_d;
    logic [15:0]  udp_len_d;
    logic [15:0]  word_d;
    logic [16:0]  acc_d;
    logic [16:0]  fold_d;
    logic [15:0]  csum_d;
    logic [335:0] hdr_d;
    logic [5:0]   nxt_idx_d;
    logic [7:0]   nxt_byte_d;

    always_comb begin
        total_len_d = len_q + 16'd28;
        udp_len_d   = len_q + 16'd8;
        word_d      = '0;
        case (cnt_q)
            4'd0: word_d = 16'h4500;
            4'd1: word_d = total_len_d;
            4'd2: word_d = id_q;
            4'd3: word_d = 16'h4000;
            4'd4: word_d = {TTL, 8'h11};
            4'd6: word_d = src_ip_q[31:16];
            4'd7: word_d = src_ip_q[15:0];
            4'd8: word_d = dst_ip_q[31:16];
            4'd9: word_d = dst_ip_q[15:0];
            default: word_d = '0;
        endcase
        // Carry is added back one step late; the final fold picks up the last one.
        acc_d  = {1'b0, acc_q[15:0]} + {16'd0, acc_q[16]} + {1'b0, word_d};
        fold_d = {1'b0, acc_q[15:0]} + {16'd0, acc_q[16]};
        csum_d = ~(fold_d[15:0] + {15'd0, fold_d[16]});
        hdr_d  = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, total_len_d,
                  id_q, 16'h4000, TTL, 8'h11, checksum_q, src_ip_q, dst_ip_q,
                  src_port_q, dst_port_q, udp_len_d, 16'h0000};
        nxt_idx_d  = idx_q + 6'd1;
        nxt_byte_d = hdr_d[(9'd335 - {nxt_idx_d, 3'b000}) -: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            checksum_q <= '0;
            id_q       <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            gap_q      <= '0;
            idx_q      <= '0;
            dst_mac_q  <= '0;
            src_mac_q  <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.tx_start) begin
                        if ({5'd0, bus.tx_payload_len} > MAX_LEN) begin
                            error_q <= 1'b1;
                        end else begin
                            len_q      <= {5'd0, bus.tx_payload_len};
                            dst_mac_q  <= bus.dst_mac;
                            src_mac_q  <= bus.src_mac;
                            src_ip_q   <= bus.src_ip;
                            dst_ip_q   <= bus.dst_ip;
                            src_port_q <= bus.src_port;
                            dst_port_q <= bus.dst_port;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= S_CHECKSUM;
                        end
                    end
                end
                S_CHECKSUM: begin
                    if (cnt_q == 4'd10) begin
                        checksum_q <= csum_d;
                        data_q     <= dst_mac_q[47:40];
                        valid_q    <= 1'b1;
                        idx_q      <= '0;
                        state_q    <= S_HEADER;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_HEADER: begin
                    if (bus.out_ready) begin
                        if (idx_q == 6'd41) begin
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            if (len_q == 16'd0) begin
                                done_q  <= 1'b1;
                                id_q    <= id_q + 16'd1;
                                gap_q   <= '0;
                                state_q <= S_GAP;
                            end else begin
                                rem_q   <= len_q;
                                state_q <= S_PAYLOAD;
                            end
                        end else begin
                            idx_q  <= nxt_idx_d;
                            data_q <= nxt_byte_d;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (!bus.in_valid) begin
                        error_q <= 1'b1;
                        id_q    <= id_q + 16'd1;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else if (bus.out_ready) begin
                        if (rem_q == 16'd1) begin
                            done_q  <= 1'b1;
                            id_q    <= id_q + 16'd1;
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end else begin
                            rem_q <= rem_q - 16'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = (state_q == S_PAYLOAD) ? bus.in_valid : valid_q;
    assign bus.out_data  = (state_q == S_PAYLOAD) ? bus.in_data  : data_q;
    assign bus.in_ready  = (state_q == S_PAYLOAD) && bus.out_ready;
    assign bus.tx_busy   = busy_q;
    assign bus.tx_done   = done_q;
    assign bus.tx_error  = error_q;
endmodule

// File: tb/tb_udp_packet_builder.sv
// Directed bench for udp_packet_builder: nominal, backpressure, underrun,
// length limits, reset mid-frame and back-to-back frames.
module tb_udp_packet_builder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    udp_packet_builder_if bus();

    udp_packet_builder #(
        .MAX_PAYLOAD(1472),
        .IP_TTL(64),
        .MIN_GAP(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cap [0:63];
    logic [7:0] pay [0:7];
    int ncap, first_valid, last_x, done_cyc, err_cyc, stab_err, ov_at_done, post_bad;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input int len,
                                            input logic [15:0] id, input logic [15:0] cs);
        logic [335:0] v;
        v = {48'h01005E010101, 48'h020000000001, 16'h0800, 8'h45, 8'h00,
             16'(28 + len), id, 16'h4000, 8'h40, 8'h11, cs,
             32'hC0A8010A, 32'hEF010101, 16'h1234, 16'h5678,
             16'(8 + len), 16'h0000};
        return v[335 - 8*i -: 8];
    endfunction

    task automatic chk16(input string tag, input int idx, input logic [15:0] exp);
        chk(tag, {16'd0, cap[idx], cap[idx+1]}, {16'd0, exp});
    endtask

    task automatic chk_frame(input string tag, input int len,
                             input logic [15:0] id, input logic [15:0] cs);
        chk({tag, "_bytes"}, ncap, 42 + len);
        for (int i = 0; i < 42 + len && i < ncap && i < 64; i++)
            chk($sformatf("%s_b%0d", tag, i), {24'd0, cap[i]},
                {24'd0, (i < 42) ? exp_byte(i, len, id, cs) : pay[(i - 42) % 8]});
    endtask

    task automatic start(input int len);
        @(negedge clk);
        bus.tx_start       = 1'b1;
        bus.tx_payload_len = 11'(len);
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    // Entered at the falling edge right after tx_start was sampled (cycle 0).
    task automatic run_frame(input int len, input int supply, input int mode,
                             input int stop_at, input int post);
        int pay_idx;
        logic prev_stall;
        logic [7:0] prev_data;
        pay_idx = 0; prev_stall = 1'b0; prev_data = '0;
        ncap = 0; first_valid = -1; last_x = -1; done_cyc = -1; err_cyc = -1;
        stab_err = 0; ov_at_done = 0; post_bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.out_ready = (mode == 0) ? 1'b1 : 1'(cyc % 2);
            bus.in_valid  = (pay_idx < supply);
            bus.in_data   = pay[pay_idx % 8];
            #1;
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (stop_at >= 0 && ncap == stop_at && bus.out_valid) break;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stab_err++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (ncap < 64) cap[ncap] = bus.out_data;
                ncap++;
                last_x = cyc;
            end
            if (bus.in_valid && bus.in_ready) pay_idx++;
            if (bus.tx_done)  begin done_cyc = cyc; ov_at_done = int'(bus.out_valid); break; end
            if (bus.tx_error) begin err_cyc = cyc; break; end
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < post; k++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid || bus.tx_done) post_bad++;
        end
    endtask

    initial begin
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
        pay[4] = 8'h11; pay[5] = 8'h22; pay[6] = 8'h33; pay[7] = 8'h44;
        reset              = 1'b0;
        bus.tx_start       = 1'b0;
        bus.tx_payload_len = '0;
        bus.dst_mac        = 48'h01005E010101;
        bus.src_mac        = 48'h020000000001;
        bus.src_ip         = 32'hC0A8010A;
        bus.dst_ip         = 32'hEF010101;
        bus.src_port       = 16'h1234;
        bus.dst_port       = 16'h5678;
        bus.in_data        = '0;
        bus.in_valid       = 1'b0;
        bus.out_ready      = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_busy",      bus.tx_busy,   0);
        chk("rst_done",      bus.tx_done,   0);
        chk("rst_error",     bus.tx_error,  0);
        chk("rst_in_ready",  bus.in_ready,  0);
        @(negedge clk);
        reset = 1'b1;

        // Nominal frame, ID 0000, checksum 8918
        start(4);
        #1;
        chk("nom_busy_rise", bus.tx_busy, 1);
        run_frame(4, 4, 0, -1, 3);
        chk("nom_first_valid", first_valid, 11);
        chk16("nom_totlen", 16, 16'h0020);
        chk16("nom_id",     18, 16'h0000);
        chk16("nom_csum",   24, 16'h8918);
        chk16("nom_dport",  36, 16'h5678);
        chk16("nom_udplen", 38, 16'h000C);
        chk_frame("nom", 4, 16'h0000, 16'h8918);
        chk("nom_done_lat",  done_cyc - last_x, 1);
        chk("nom_no_error",  err_cyc, -1);
        chk("nom_gap_valid", ov_at_done, 0);
        chk("nom_post",      post_bad, 0);

        // Backpressure, ID 0001, checksum 8917
        start(4);
        run_frame(4, 4, 1, -1, 3);
        chk_frame("bp", 4, 16'h0001, 16'h8917);
        chk("bp_stable",   stab_err, 0);
        chk("bp_done_lat", done_cyc - last_x, 1);

        // Underrun after 3 of 8 bytes, ID 0002, checksum 8912
        start(8);
        run_frame(8, 3, 0, -1, 3);
        chk("ur_bytes",    ncap, 45);
        chk("ur_error",    err_cyc >= 0, 1);
        chk("ur_no_done",  done_cyc, -1);
        chk("ur_post",     post_bad, 0);
        chk16("ur_id",     18, 16'h0002);
        chk16("ur_csum",   24, 16'h8912);
        chk("ur_last_pay", {24'd0, cap[44]}, 32'h000000CC);

        // Next frame after underrun: ID 0003, checksum 8915
        start(4);
        run_frame(4, 4, 0, -1, 3);
        chk("ur2_bytes", ncap, 46);
        chk16("ur2_id",   18, 16'h0003);
        chk16("ur2_csum", 24, 16'h8915);

        // Oversized length rejected
        start(1473);
        #1;
        chk("lim_error", bus.tx_error, 1);
        chk("lim_busy",  bus.tx_busy,  0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid || bus.tx_busy) bad++;
        end
        chk("lim_quiet", bad, 0);

        // Zero-length payload, ID 0004, checksum 8918
        start(0);
        run_frame(0, 0, 0, -1, 3);
        chk("z_bytes", ncap, 42);
        chk16("z_totlen", 16, 16'h001C);
        chk16("z_udplen", 38, 16'h0008);
        chk16("z_id",     18, 16'h0004);
        chk16("z_csum",   24, 16'h8918);
        chk("z_done_lat", done_cyc - last_x, 1);

        // Reset while header byte 20 is on the bus
        start(4);
        run_frame(4, 4, 0, 20, 0);
        chk("mid_bytes",  ncap, 20);
        chk("mid_byte20", bus.out_data, 8'h40);
        reset = 1'b0;
        #1;
        chk("mid_valid", bus.out_valid, 0);
        chk("mid_busy",  bus.tx_busy,   0);
        chk("mid_data",  bus.out_data,  0);
        @(negedge clk);
        reset = 1'b1;

        // First frame after reset: ID restarts at 0000
        start(4);
        run_frame(4, 4, 0, -1, 0);
        chk_frame("post_rst", 4, 16'h0000, 16'h8918);
        chk("post_rst_done_lat", done_cyc - last_x, 1);

        // tx_start during the gap is ignored; one cycle after busy falls it is taken
        bus.tx_start       = 1'b1;
        bus.tx_payload_len = 11'd4;
        @(negedge clk);
        #1;
        chk("b2b_gap_ignored", bus.tx_busy, 0);
        @(negedge clk);
        bus.tx_start = 1'b0;
        #1;
        chk("b2b_accepted", bus.tx_busy, 1);
        run_frame(4, 4, 0, -1, 3);
        chk("b2b_first_valid", first_valid, 11);
        chk_frame("b2b", 4, 16'h0001, 16'h8917);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/udp_packet_builder.md
Name: udp_packet_builder

Overview:
Transmit-side counterpart of the UDP receive filter: builds complete Ethernet/IPv4/UDP frames around a caller-supplied payload.
- Emits the frame as a contiguous byte stream: 42 header bytes, then the payload passed through from an upstream source.
- Computes the IPv4 header checksum before the frame starts.
- Its output is byte-compatible with the receive filter: same header offsets, and end of frame is marked by valid falling.

Parameters:
MAX_PAYLOAD, 1472, largest accepted payload length in bytes
IP_TTL, 64, value placed in IPv4 TTL byte
MIN_GAP, 1, idle cycles (out_valid low) forced between frames, >=1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
tx_start  in  1  one-cycle request to build a frame
tx_payload_len  in  11  payload byte count, sampled with tx_start
dst_mac  in  48  Ethernet destination
src_mac  in  48  Ethernet source
src_ip  in  32  IPv4 source
dst_ip  in  32  IPv4 destination
src_port  in  16  UDP source port
dst_port  in  16  UDP destination port
in_data  in  8  payload byte
in_valid  in  1  payload byte valid
in_ready  out  1  builder accepts payload byte
out_data  out  8  frame byte
out_valid  out  1  frame byte valid
out_ready  in  1  downstream accepts byte
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse on last byte transfer
tx_error  out  1  one-cycle pulse: length reject or payload underrun

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_IDLE; IP identification counter=0.
  - All outputs 0 immediately, including out_data=0x00. No partial frame resumes after reset.
- States: S_IDLE, S_CHECKSUM, S_HEADER, S_PAYLOAD, S_GAP.
- S_IDLE, tx_start=1:
  - If tx_payload_len > MAX_PAYLOAD: pulse tx_error next cycle and stay in S_IDLE.
  - Otherwise latch all config inputs and the length, go to S_CHECKSUM, and set tx_busy=1 from the next cycle.
- tx_start is ignored while tx_busy=1.
- S_CHECKSUM: 10 cycles, one 16-bit header word summed per cycle, checksum word taken as 0.
  - Ones-complement accumulation with end-around carry; fold, then invert.
  - out_valid first rises on the 11th rising edge after tx_start is sampled.
- S_HEADER emits bytes 0..41, MSB-first per field:
  - 0-5 dst_mac; 6-11 src_mac; 12-13 0x0800
  - 14 0x45; 15 0x00; 16-17 total length = 28+len; 18-19 ID; 20-21 0x4000; 22 IP_TTL; 23 0x11; 24-25 checksum
  - 26-29 src_ip; 30-33 dst_ip; 34-35 src_port; 36-37 dst_port; 38-39 UDP length = 8+len; 40-41 0x0000 (UDP checksum disabled)
- Transfer rule: a byte transfers when out_valid && out_ready.
  - In S_HEADER, out_valid stays 1 and out_data holds stable while out_ready=0. in_ready=0.
- S_PAYLOAD: pass-through with out_data=in_data, out_valid=in_valid, in_ready=out_ready. A 16-bit counter tracks remaining bytes.
  - Underrun: in_valid=0 with bytes remaining. out_valid is 0 that cycle, which terminates the frame for the receiver. Pulse tx_error, no tx_done, go to S_GAP. Any further payload bytes are not accepted (in_ready=0).
- len=0: skip S_PAYLOAD; byte 41 is the last byte.
- Last byte transfer (header or payload):
  - Pulse tx_done in the following cycle; ID increments (0xFFFF wraps to 0x0000). ID also increments on an underrun frame.
  - Go to S_GAP.
- S_GAP: out_valid=0 for MIN_GAP cycles, then S_IDLE; tx_busy falls on entry to S_IDLE.
  - A tx_start arriving during S_GAP is ignored.
- All sums use 17-bit accumulators; length fields are computed in 16 bits (max 1500, no overflow).

Test Plan:
- Nominal frame, len=4, config dst_mac 01005E010101, src_mac 020000000001, src_ip C0A8010A, dst_ip EF010101, ports 1234/5678 (hex), first frame after reset, out_ready=1, 4 contiguous payload bytes AA BB CC DD:
  - 46 bytes out; bytes 16-17=00 20; 18-19=00 00; 24-25=89 18; 36-37=56 78; 38-39=00 0C; 42-45=AA BB CC DD.
  - tx_done one cycle after byte 45; out_valid low for at least 1 cycle afterwards.
- Backpressure: same frame with out_ready toggled 0/1 every cycle -> identical byte sequence. No byte duplicated or dropped; out_data stable while out_ready=0.
- Underrun: len=8, in_valid dropped after 3 payload bytes -> 45 bytes transferred, tx_error pulse, no tx_done, next frame's ID = previous+1.
- Limits: len=1473 -> tx_error, tx_busy stays 0, no out_valid. len=0 -> exactly 42 bytes with 16-17=00 1C and 38-39=00 08.
- Reset mid-frame: assert reset at header byte 20 -> out_valid=0, tx_busy=0 immediately. After release, the next frame uses ID=0000 and checksum 8918 with the nominal config and len=4.
- Back-to-back: tx_start during S_GAP is ignored; tx_start one cycle after tx_busy falls is accepted. Second frame ID=0001, checksum 8917.
